// File: rtl/scroll_cam.sv
// Camera/background scroll controller: dead-zone tracking of char_x with per-frame
// rate limit and level clamping, plus lock, one-way mode and a scripted pan-to-target.
module scroll_cam #(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned MAX_POS      = 480,
  parameter int unsigned LEFT_MARGIN  = 90,
  parameter int unsigned RIGHT_MARGIN = 270,
  parameter int unsigned MAX_STEP     = 4,
  parameter int unsigned PAN_STEP     = 8,
  parameter int unsigned ONE_WAY      = 0
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] char_x,
  input  logic               lock,
  input  logic               pan_req,
  input  logic [COORD_W-1:0] pan_pos,
  output logic [COORD_W-1:0] bg_pos,
  output logic [COORD_W:0]   scroll_dx,
  output logic               moved,
  output logic               busy,
  output logic               at_min,
  output logic               at_max
);

  localparam int unsigned W2 = COORD_W + 2;
  typedef logic [W2-1:0] wide_t;

  localparam wide_t MAXP  = wide_t'(MAX_POS);
  localparam wide_t LMARG = wide_t'(LEFT_MARGIN);
  localparam wide_t RMARG = wide_t'(RIGHT_MARGIN);
  localparam wide_t MSTEP = wide_t'(MAX_STEP);
  localparam wide_t PSTEP = wide_t'(PAN_STEP);
  localparam bit    ONE_WAY_EN = (ONE_WAY != 0);

  typedef enum logic [1:0] {TRACK, LOCKED, PAN} state_t;

  state_t             state;
  logic [COORD_W-1:0] target;

  wide_t              pos_w, cx_w, tgt_w, right_edge, left_edge;
  wide_t              step_w, new_pos_w, dx_w;
  logic               up, apply;
  logic [COORD_W-1:0] pan_tgt;

  function automatic wide_t min2(input wide_t a, input wide_t b);
    return (a < b) ? a : b;
  endfunction

  always_comb begin
    pos_w      = wide_t'(bg_pos);
    cx_w       = wide_t'(char_x);
    tgt_w      = wide_t'(target);
    right_edge = pos_w + RMARG;
    left_edge  = pos_w + LMARG;
    step_w     = '0;
    up         = 1'b0;
    if (state == PAN) begin
      up     = tgt_w > pos_w;
      step_w = min2(PSTEP, up ? (tgt_w - pos_w) : (pos_w - tgt_w));
    end else if (cx_w > right_edge) begin
      up     = 1'b1;
      step_w = min2(min2(cx_w - right_edge, MSTEP), MAXP - pos_w);
    end else if ((cx_w < left_edge) && !ONE_WAY_EN) begin
      step_w = min2(min2(left_edge - cx_w, MSTEP), pos_w);
    end
    new_pos_w = up ? (pos_w + step_w) : (pos_w - step_w);
    dx_w      = up ? step_w : (wide_t'(0) - step_w);
    pan_tgt   = (wide_t'(pan_pos) > MAXP) ? COORD_W'(MAX_POS) : pan_pos;
    // A pan_req cycle only latches the target; lock freezes TRACK on the cycle it is seen.
    apply     = frame_tick && !pan_req &&
                (((state == TRACK) && !lock) || ((state == PAN) && (pos_w != tgt_w)));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= TRACK;
      target    <= '0;
      bg_pos    <= '0;
      scroll_dx <= '0;
      moved     <= 1'b0;
      busy      <= 1'b0;
      at_min    <= 1'b1;
      at_max    <= 1'b0;
    end else begin
      moved <= 1'b0;
      if (frame_tick) scroll_dx <= apply ? dx_w[COORD_W:0] : '0;
      if (apply) begin
        bg_pos <= new_pos_w[COORD_W-1:0];
        moved  <= (dx_w != '0);
        at_min <= (new_pos_w == '0);
        at_max <= (new_pos_w == MAXP);
      end
      if (pan_req) begin
        target <= pan_tgt;
        state  <= PAN;
        busy   <= 1'b1;
      end else begin
        case (state)
          TRACK:   if (lock) state <= LOCKED;
          LOCKED:  if (!lock) state <= TRACK;
          PAN: begin
            if (pos_w == tgt_w) begin
              state <= lock ? LOCKED : TRACK;
              busy  <= 1'b0;
            end
          end
          default: state <= TRACK;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scroll_cam.sv
// Scoreboard bench for scroll_cam: expected bg_pos/scroll_dx/moved pushed per tick,
// popped and compared once the update is visible.
module tb_scroll_cam;

  localparam int W = 10;
  localparam int MAXP = 480;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic [W-1:0]  char_x = '0;
  logic          lock = 1'b0;
  logic          pan_req = 1'b0;
  logic [W-1:0]  pan_pos = '0;
  logic [W-1:0]  bg_pos, ow_bg_pos;
  logic [W:0]    scroll_dx, ow_scroll_dx;
  logic          moved, busy, at_min, at_max;
  logic          ow_moved, ow_busy, ow_at_min, ow_at_max;

  typedef struct {
    logic [W-1:0] bg;
    logic [W:0]   dx;
    logic         mv;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests_run = 0;
  int   fails = 0;

  scroll_cam #(.COORD_W(W), .MAX_POS(MAXP), .ONE_WAY(0)) u_dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_tick(frame_tick), .char_x(char_x),
    .lock(lock), .pan_req(pan_req), .pan_pos(pan_pos), .bg_pos(bg_pos),
    .scroll_dx(scroll_dx), .moved(moved), .busy(busy), .at_min(at_min), .at_max(at_max));

  scroll_cam #(.COORD_W(W), .MAX_POS(MAXP), .ONE_WAY(1)) u_dut_ow (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .frame_tick(frame_tick), .char_x(char_x),
    .lock(lock), .pan_req(pan_req), .pan_pos(pan_pos), .bg_pos(ow_bg_pos),
    .scroll_dx(ow_scroll_dx), .moved(ow_moved), .busy(ow_busy), .at_min(ow_at_min),
    .at_max(ow_at_max));

  always #5 sys_clk = ~sys_clk;

  // All stimulus tasks start and end on a negedge.
  task automatic do_reset();
    sys_rst_n = 1'b0; frame_tick = 1'b0; pan_req = 1'b0; lock = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    sb.delete();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge sys_clk);
    frame_tick = 1'b0;
  endtask

  task automatic pan(input int p);
    pan_req = 1'b1; pan_pos = W'(p);
    @(negedge sys_clk);
    pan_req = 1'b0;
  endtask

  task automatic pan_to(input int p);
    pan(p);
    for (int n = 0; n < 200; n++) begin
      if (!busy) break;
      tick();
    end
    if (busy) begin
      fails++;
      $display("FAIL pan_timeout: busy=%0d still high, want 0", busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({bg_pos, scroll_dx, moved, busy, at_min, at_max} !== {10'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got bg=%0d dx=%0d mv=%0d busy=%0d min=%0d max=%0d, want 0 0 0 0 1 0",
               bg_pos, scroll_dx, moved, busy, at_min, at_max);
    end
  endtask

  task automatic test_track_right();
    int exp_bg[4] = '{4, 8, 10, 10};
    int exp_dx[4] = '{4, 4, 2, 0};
    do_reset();
    char_x = 10'd280;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{W'(exp_bg[i]), (W+1)'(exp_dx[i]), exp_dx[i] != 0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({bg_pos, scroll_dx, moved} !== {e.bg, e.dx, e.mv}) begin
        fails++;
        $display("FAIL track_right[%0d]: got bg=%0d dx=%0d mv=%0d, want bg=%0d dx=%0d mv=%0d",
                 i, bg_pos, $signed(scroll_dx), moved, e.bg, $signed(e.dx), e.mv);
      end
    end
  endtask

  task automatic test_max_clamp();
    do_reset();
    pan_to(478);
    tests_run++;
    if (bg_pos !== 10'd478) begin
      fails++;
      $display("FAIL max_pan_setup: got bg=%0d, want 478", bg_pos);
    end
    char_x = 10'd900;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{10'd480, (i == 0) ? 11'd2 : 11'd0, i == 0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({bg_pos, scroll_dx, moved, at_max} !== {e.bg, e.dx, e.mv, 1'b1}) begin
        fails++;
        $display("FAIL max_clamp[%0d]: got bg=%0d dx=%0d mv=%0d max=%0d, want bg=%0d dx=%0d mv=%0d max=1",
                 i, bg_pos, $signed(scroll_dx), moved, at_max, e.bg, $signed(e.dx), e.mv);
      end
    end
  endtask

  task automatic test_track_left_one_way();
    do_reset();
    char_x = 10'd200;
    pan_to(100);
    char_x = 10'd188;
    sb.push_back('{10'd98, 11'(-2), 1'b1});
    sb.push_back('{10'd100, 11'd0, 1'b0});
    tick();
    e = sb.pop_front();
    tests_run++;
    if ({bg_pos, scroll_dx, moved} !== {e.bg, e.dx, e.mv}) begin
      fails++;
      $display("FAIL track_left: got bg=%0d dx=%0d mv=%0d, want bg=%0d dx=%0d mv=%0d",
               bg_pos, $signed(scroll_dx), moved, e.bg, $signed(e.dx), e.mv);
    end
    e = sb.pop_front();
    tests_run++;
    if ({ow_bg_pos, ow_scroll_dx, ow_moved} !== {e.bg, e.dx, e.mv}) begin
      fails++;
      $display("FAIL one_way_hold: got bg=%0d dx=%0d mv=%0d, want bg=%0d dx=%0d mv=%0d",
               ow_bg_pos, $signed(ow_scroll_dx), ow_moved, e.bg, $signed(e.dx), e.mv);
    end
  endtask

  task automatic test_pan_retarget();
    int m;
    int d;
    do_reset();
    pan(600);
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL pan_busy_rise: got busy=%0d, want 1", busy);
    end
    m = 0;
    for (int i = 0; i < 60; i++) begin
      m = m + 8;
      sb.push_back('{W'(m), 11'd8, 1'b1});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({bg_pos, scroll_dx, moved} !== {e.bg, e.dx, e.mv}) begin
        fails++;
        $display("FAIL pan_up[%0d]: got bg=%0d dx=%0d mv=%0d, want bg=%0d dx=%0d mv=%0d",
                 i, bg_pos, $signed(scroll_dx), moved, e.bg, $signed(e.dx), e.mv);
      end
    end
    @(negedge sys_clk);
    tests_run++;
    if ({busy, at_max, bg_pos} !== {1'b0, 1'b1, 10'd480}) begin
      fails++;
      $display("FAIL pan_clamp_done: got busy=%0d max=%0d bg=%0d, want 0 1 480", busy, at_max, bg_pos);
    end
    pan(200);
    for (int i = 0; i < 5; i++) tick();
    m = 440;
    // Retarget on the same cycle as frame_tick: latch only, no motion.
    pan_req = 1'b1; pan_pos = 10'd100; frame_tick = 1'b1;
    sb.push_back('{W'(m), 11'd0, 1'b0});
    @(negedge sys_clk);
    pan_req = 1'b0; frame_tick = 1'b0;
    e = sb.pop_front();
    tests_run++;
    if ({bg_pos, scroll_dx, moved, busy} !== {e.bg, e.dx, e.mv, 1'b1}) begin
      fails++;
      $display("FAIL pan_same_cycle: got bg=%0d dx=%0d mv=%0d busy=%0d, want bg=%0d dx=0 mv=0 busy=1",
               bg_pos, $signed(scroll_dx), moved, busy, e.bg);
    end
    for (int i = 0; i < 100 && m != 100; i++) begin
      d = (m - 100 < 8) ? (m - 100) : 8;
      m = m - d;
      sb.push_back('{W'(m), 11'(-d), 1'b1});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({bg_pos, scroll_dx, moved} !== {e.bg, e.dx, e.mv}) begin
        fails++;
        $display("FAIL pan_down[%0d]: got bg=%0d dx=%0d mv=%0d, want bg=%0d dx=%0d mv=%0d",
                 i, bg_pos, $signed(scroll_dx), moved, e.bg, $signed(e.dx), e.mv);
      end
    end
    @(negedge sys_clk);
    tests_run++;
    if ({busy, bg_pos} !== {1'b0, 10'd100}) begin
      fails++;
      $display("FAIL retarget_done: got busy=%0d bg=%0d, want busy=0 bg=100", busy, bg_pos);
    end
  endtask

  task automatic test_lock();
    do_reset();
    char_x = 10'd400;
    lock = 1'b1;
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{10'd0, 11'd0, 1'b0});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({bg_pos, scroll_dx, moved} !== {e.bg, e.dx, e.mv}) begin
        fails++;
        $display("FAIL locked_hold[%0d]: got bg=%0d dx=%0d mv=%0d, want bg=0 dx=0 mv=0",
                 i, bg_pos, $signed(scroll_dx), moved);
      end
    end
    lock = 1'b0;
    @(negedge sys_clk);
    for (int i = 1; i <= 3; i++) begin
      sb.push_back('{W'(4 * i), 11'd4, 1'b1});
      tick();
      e = sb.pop_front();
      tests_run++;
      if ({bg_pos, scroll_dx, moved} !== {e.bg, e.dx, e.mv}) begin
        fails++;
        $display("FAIL unlock_track[%0d]: got bg=%0d dx=%0d mv=%0d, want bg=%0d dx=%0d mv=%0d",
                 i, bg_pos, $signed(scroll_dx), moved, e.bg, $signed(e.dx), e.mv);
      end
    end
    lock = 1'b1;
    @(negedge sys_clk);
    pan_to(200);
    tests_run++;
    if (bg_pos !== 10'd200) begin
      fails++;
      $display("FAIL locked_pan: got bg=%0d, want 200", bg_pos);
    end
    // Tracking would step right here if the pan had returned to TRACK.
    char_x = 10'd900;
    sb.push_back('{10'd200, 11'd0, 1'b0});
    tick();
    e = sb.pop_front();
    tests_run++;
    if ({bg_pos, scroll_dx, moved} !== {e.bg, e.dx, e.mv}) begin
      fails++;
      $display("FAIL relock_after_pan: got bg=%0d dx=%0d mv=%0d, want bg=200 dx=0 mv=0",
               bg_pos, $signed(scroll_dx), moved);
    end
    lock = 1'b0;
  endtask

  task automatic test_reset_mid_pan();
    do_reset();
    char_x = 10'd280;
    pan(480);
    repeat (3) tick();
    #2 sys_rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bg_pos, busy, at_min} !== {10'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset: got bg=%0d busy=%0d min=%0d, want 0 0 1", bg_pos, busy, at_min);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    sb.push_back('{10'd4, 11'd4, 1'b1});
    tick();
    e = sb.pop_front();
    tests_run++;
    if ({bg_pos, scroll_dx, moved, busy} !== {e.bg, e.dx, e.mv, 1'b0}) begin
      fails++;
      $display("FAIL track_after_reset: got bg=%0d dx=%0d mv=%0d busy=%0d, want bg=4 dx=4 mv=1 busy=0",
               bg_pos, $signed(scroll_dx), moved, busy);
    end
  endtask

  initial begin
    test_reset();
    test_track_right();
    test_max_clamp();
    test_track_left_one_way();
    test_pan_retarget();
    test_lock();
    test_reset_mid_pan();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
